// File: rtl/opcodes_pkg.sv
// Shared definitions for the memory alignment unit.
//   state_t      : alignment FSM state encoding (IDLE, ACC1, ACC2, DONE)
//   F3_*         : RV32I funct3 codes for loads and stores
//   size_mask()  : byte-lane mask of an access before it is shifted to its offset
//   is_split()   : true when an access crosses a 32-bit word boundary
package opcodes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Offset plus size exceeds four bytes.
  function automatic logic is_split(input logic [1:0] size, input logic [1:0] offset);
    is_split = ((size == 2'b10) && (offset != 2'b00)) ||
               ((size == 2'b01) && (offset == 2'b11));
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load result extraction and extension.
//   raw    : {high word, low word} as read from the bus (high word unused when
//            the access does not cross a word boundary)
//   offset : byte offset of the access inside the low word
//   funct3 : RV32I load code
//   result : byte/half/word shifted down to bit 0, sign- or zero-extended
module load_extend
  import opcodes_pkg::*;
(
  input  logic [63:0] raw,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] word;

  assign word = 32'(raw >> {offset, 3'b000});

  always_comb begin
    result = word;
    case (funct3)
      F3_LB:   result = {{24{word[7]}}, word[7:0]};
      F3_LH:   result = {{16{word[15]}}, word[15:0]};
      F3_LBU:  result = {24'h000000, word[7:0]};
      F3_LHU:  result = {16'h0000, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_align_unit.sv
// Memory alignment unit: turns one RV32I load/store from EX/MEM into one or
// two word-aligned bus accesses, merging/extending load data.
//   clk, rst        : clock, asynchronous active-high reset
//   mem_op_i/mem_we_i/funct3_i/addr_i/wdata_i : request from EX/MEM
//   bus_*           : word-aligned bus; bus_ack_i = read data valid / write accepted
//   read_data_o     : extended load result of a single-access load (valid in DONE)
//   merged_word_o   : extended load result of a split load (valid in DONE)
//   stall_o         : freezes the pipeline while the access is in flight
//   state_dbg       : current FSM state
//
// Bus handshake: bus_req_o rises on entry to ACC1/ACC2 with address, data and
// strobes stable, and they stay unchanged until a cycle with bus_ack_i=1; that
// cycle completes the access. bus_ack_i in any other state is ignored.
module mem_align_unit
  import opcodes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_op_i,
  input  logic        mem_we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic [31:0] read_data_o,
  output logic [31:0] merged_word_o,
  output logic        stall_o,
  output state_t      state_dbg
);

  state_t      state_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        split_q;
  logic [31:0] lo_q;
  logic [31:0] hi_q;

  logic [1:0]  cur_off;
  logic [1:0]  cur_size;
  logic [7:0]  strb8;
  logic [31:0] wdata_first;
  logic [31:0] wdata_second;
  logic [31:0] lo_src;
  logic [31:0] hi_src;
  logic [31:0] ext;

  // Requests are taken from the ports only in IDLE; afterwards the latched copy.
  assign cur_off  = (state_q == IDLE) ? addr_i[1:0]   : off_q;
  assign cur_size = (state_q == IDLE) ? funct3_i[1:0] : f3_q[1:0];

  // Low nibble: lanes of the first word, high nibble: lanes spilling into the next.
  assign strb8 = {4'b0000, size_mask(cur_size)} << cur_off;

  assign wdata_first  = wdata_i << {addr_i[1:0], 3'b000};
  // Only reached for split stores, so the offset is never 0 here.
  assign wdata_second = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});

  // Feed the extender with the word arriving this cycle so the result can be
  // registered on the same ack edge. hi bits never reach a non-split result.
  assign lo_src = (state_q == ACC1) ? bus_rdata_i : lo_q;
  assign hi_src = (state_q == ACC2) ? bus_rdata_i : hi_q;

  load_extend u_load_extend (
    .raw    ({hi_src, lo_src}),
    .offset (off_q),
    .funct3 (f3_q),
    .result (ext)
  );

  assign stall_o   = ((state_q == IDLE) && mem_op_i) || (state_q == ACC1) || (state_q == ACC2);
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      off_q         <= 2'b00;
      f3_q          <= 3'b000;
      wdata_q       <= 32'h0;
      we_q          <= 1'b0;
      split_q       <= 1'b0;
      lo_q          <= 32'h0;
      hi_q          <= 32'h0;
      bus_req_o     <= 1'b0;
      bus_we_o      <= 1'b0;
      bus_addr_o    <= 32'h0;
      bus_wdata_o   <= 32'h0;
      bus_wstrb_o   <= 4'b0000;
      read_data_o   <= 32'h0;
      merged_word_o <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op_i) begin
            state_q     <= ACC1;
            off_q       <= addr_i[1:0];
            f3_q        <= funct3_i;
            wdata_q     <= wdata_i;
            we_q        <= mem_we_i;
            split_q     <= is_split(funct3_i[1:0], addr_i[1:0]);
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_wdata_o <= mem_we_i ? wdata_first : 32'h0;
            bus_wstrb_o <= mem_we_i ? strb8[3:0] : 4'b0000;
          end
        end
        ACC1: begin
          if (bus_ack_i) begin
            if (!we_q) begin
              lo_q <= bus_rdata_i;
            end
            if (split_q) begin
              state_q     <= ACC2;
              bus_addr_o  <= bus_addr_o + 32'd4;
              bus_wdata_o <= we_q ? wdata_second : 32'h0;
              bus_wstrb_o <= we_q ? strb8[7:4] : 4'b0000;
            end else begin
              state_q     <= DONE;
              bus_req_o   <= 1'b0;
              bus_we_o    <= 1'b0;
              bus_wstrb_o <= 4'b0000;
              if (!we_q) begin
                read_data_o <= ext;
              end
            end
          end
        end
        ACC2: begin
          if (bus_ack_i) begin
            state_q     <= DONE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_wstrb_o <= 4'b0000;
            if (!we_q) begin
              hi_q          <= bus_rdata_i;
              merged_word_o <= ext;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit: inputs change on the falling edge,
// outputs are checked on the falling edge (or 1ns after a falling-edge drive
// for the combinational stall).
module tb_mem_align_unit;
  import opcodes_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        mem_op;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] read_data;
  logic [31:0] merged_word;
  logic        stall;
  state_t      state_dbg;

  int checks = 0;
  int passed = 0;

  mem_align_unit dut (
    .clk           (clk),
    .rst           (rst),
    .mem_op_i      (mem_op),
    .mem_we_i      (mem_we),
    .funct3_i      (funct3),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .bus_req_o     (bus_req),
    .bus_we_o      (bus_we),
    .bus_addr_o    (bus_addr),
    .bus_wdata_o   (bus_wdata),
    .bus_wstrb_o   (bus_wstrb),
    .bus_rdata_i   (bus_rdata),
    .bus_ack_i     (bus_ack),
    .read_data_o   (read_data),
    .merged_word_o (merged_word),
    .stall_o       (stall),
    .state_dbg     (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request in IDLE and move into ACC1.
  task automatic start_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
    mem_op = 1'b1;
    mem_we = we;
    funct3 = f3;
    addr   = a;
    wdata  = d;
    #1;
    chk({tag, ".idle_stall"}, 32'(stall), 32'd1);
    step();
  endtask

  task automatic chk_bus(input string tag, input logic we, input logic [31:0] a,
                         input logic [3:0] strb, input logic [31:0] d);
    chk({tag, ".req"},   32'(bus_req), 32'd1);
    chk({tag, ".stall"}, 32'(stall), 32'd1);
    chk({tag, ".we"},    32'(bus_we), 32'(we));
    chk({tag, ".addr"},  bus_addr, a);
    chk({tag, ".strb"},  32'(bus_wstrb), 32'(strb));
    if (we) chk({tag, ".wdata"}, bus_wdata, d);
  endtask

  task automatic ack(input logic [31:0] d);
    bus_ack   = 1'b1;
    bus_rdata = d;
    step();
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
  endtask

  // In DONE: check completion, release the request, return to IDLE.
  task automatic finish_op(input string tag);
    chk({tag, ".done_state"}, 32'(state_dbg), 32'(DONE));
    chk({tag, ".done_stall"}, 32'(stall), 32'd0);
    chk({tag, ".done_req"},   32'(bus_req), 32'd0);
    mem_op = 1'b0;
    step();
    chk({tag, ".back_idle"},  32'(state_dbg), 32'(IDLE));
  endtask

  initial begin
    mem_op = 0; mem_we = 0; funct3 = 0; addr = 0; wdata = 0;
    bus_rdata = 0; bus_ack = 0;
    step(); step();
    chk("rst.req",    32'(bus_req), 32'd0);
    chk("rst.stall",  32'(stall), 32'd0);
    chk("rst.addr",   bus_addr, 32'h0);
    chk("rst.wstrb",  32'(bus_wstrb), 32'd0);
    chk("rst.rdata",  read_data, 32'h0);
    chk("rst.merged", merged_word, 32'h0);
    rst = 1'b0;
    step(); step();
    chk("idle.noop_req",   32'(bus_req), 32'd0);
    chk("idle.noop_stall", 32'(stall), 32'd0);

    // LW aligned
    start_op("lw100", 1'b0, F3_LW, 32'h100, 32'h0);
    chk_bus("lw100.a1", 1'b0, 32'h100, 4'b0000, 32'h0);
    ack(32'hDEADBEEF);
    chk("lw100.result", read_data, 32'hDEADBEEF);
    finish_op("lw100");

    // LW split
    start_op("lw102", 1'b0, F3_LW, 32'h102, 32'h0);
    chk_bus("lw102.a1", 1'b0, 32'h100, 4'b0000, 32'h0);
    ack(32'h11223344);
    chk_bus("lw102.a2", 1'b0, 32'h104, 4'b0000, 32'h0);
    ack(32'h55667788);
    chk("lw102.merged", merged_word, 32'h77881122);
    finish_op("lw102");

    // SW split
    start_op("sw203", 1'b1, F3_SW, 32'h203, 32'hAABBCCDD);
    chk_bus("sw203.a1", 1'b1, 32'h200, 4'b1000, 32'hDD000000);
    ack(32'h0);
    chk_bus("sw203.a2", 1'b1, 32'h204, 4'b0111, 32'h00AABBCC);
    ack(32'h0);
    chk("sw203.we_low", 32'(bus_we), 32'd0);
    finish_op("sw203");

    // SH aligned to upper half
    start_op("sh502", 1'b1, F3_SH, 32'h502, 32'h1234ABCD);
    chk_bus("sh502.a1", 1'b1, 32'h500, 4'b1100, 32'hABCD0000);
    ack(32'h0);
    finish_op("sh502");

    // LB sign extension
    start_op("lb301", 1'b0, F3_LB, 32'h301, 32'h0);
    chk_bus("lb301.a1", 1'b0, 32'h300, 4'b0000, 32'h0);
    ack(32'h0000800F);
    chk("lb301.result", read_data, 32'hFFFFFF80);
    finish_op("lb301");

    // LHU split
    start_op("lhu303", 1'b0, F3_LHU, 32'h303, 32'h0);
    ack(32'hAB000000);
    chk_bus("lhu303.a2", 1'b0, 32'h304, 4'b0000, 32'h0);
    ack(32'h000000CD);
    chk("lhu303.merged", merged_word, 32'h0000CDAB);
    finish_op("lhu303");

    // LH at top of address space, delayed second ack
    start_op("lhtop", 1'b0, F3_LH, 32'hFFFFFFFF, 32'h0);
    chk_bus("lhtop.a1", 1'b0, 32'hFFFFFFFC, 4'b0000, 32'h0);
    ack(32'hA5000000);
    for (int i = 0; i < 5; i++) begin
      chk_bus("lhtop.wait", 1'b0, 32'h00000000, 4'b0000, 32'h0);
      step();
    end
    ack(32'h000000C3);
    chk("lhtop.merged", merged_word, 32'hFFFFC3A5);
    finish_op("lhtop");

    // Reset during ACC2, late ack ignored
    start_op("rstacc2", 1'b0, F3_LW, 32'h106, 32'h0);
    ack(32'h01020304);
    chk("rstacc2.in_acc2", 32'(state_dbg), 32'(ACC2));
    rst    = 1'b1;
    mem_op = 1'b0;
    #1;
    chk("rstacc2.req",   32'(bus_req), 32'd0);
    chk("rstacc2.stall", 32'(stall), 32'd0);
    chk("rstacc2.state", 32'(state_dbg), 32'(IDLE));
    step();
    rst = 1'b0;
    ack(32'hCAFEF00D);
    chk("rstacc2.late_state",  32'(state_dbg), 32'(IDLE));
    chk("rstacc2.late_req",    32'(bus_req), 32'd0);
    chk("rstacc2.late_merged", merged_word, 32'h0);

    start_op("lw400", 1'b0, F3_LW, 32'h400, 32'h0);
    chk_bus("lw400.a1", 1'b0, 32'h400, 4'b0000, 32'h0);
    ack(32'h0BADF00D);
    chk("lw400.result", read_data, 32'h0BADF00D);
    finish_op("lw400");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_align_unit.md
MEM_ALIGN_UNIT -- requirements
Module: mem_align_unit

Interface
REQ-001 SHALL have ports: clk input 1, system clock; rst input 1, reset (asynchronous, active-high).
REQ-002 SHALL have ports: mem_op_i input 1, EX/MEM holds a load/store; mem_we_i input 1, 1=store; funct3_i input 3, RV32I size/sign code.
REQ-003 SHALL have ports: addr_i input 32, byte address from ALU; wdata_i input 32, store data (rs2).
REQ-004 SHALL have ports: bus_req_o output 1, bus_we_o output 1, bus_addr_o output 32 (word-aligned), bus_wdata_o output 32, bus_wstrb_o output 4.
REQ-005 SHALL have ports: bus_rdata_i input 32, bus_ack_i input 1, read data valid / write accepted.
REQ-006 SHALL have ports: read_data_o output 32, extended load result for non-split accesses; merged_word_o output 32, extended load result for split accesses.
REQ-007 SHALL have port stall_o output 1, freeze IF..EX/MEM and hold MEM/WB bubble.

Function
REQ-008 SHALL implement FSM states IDLE, ACC1, ACC2, DONE.
REQ-009 SHALL treat an access as split when the byte offset plus the size exceeds 4: word with addr_i[1:0]!=0, or half with addr_i[1:0]==3.
REQ-010 SHALL combinationally assert stall_o when the FSM is in IDLE with mem_op_i=1, and in ACC1 and ACC2; stall_o SHALL be 0 in DONE.
REQ-011 SHALL move IDLE->ACC1 when mem_op_i=1. SHALL move ACC1->ACC2 on bus_ack_i if the access is split, otherwise ACC1->DONE. SHALL move ACC2->DONE on bus_ack_i. SHALL move DONE->IDLE unconditionally.
REQ-012 SHALL drive bus_req_o as a Moore output: 1 in ACC1/ACC2, held until bus_ack_i; minimum latency is 3 cycles aligned, 4 cycles split.
REQ-013 SHALL drive bus_addr_o with {addr_i[31:2],2'b00} in ACC1 and that value +4 in ACC2 (mod 2^32; 0xFFFFFFFC+4 wraps to 0x00000000).
REQ-014 Store, offset k=addr_i[1:0]: SHALL drive ACC1 with wstrb=(size mask<<k)[3:0] and wdata=wdata_i<<8k; SHALL drive ACC2 with the remaining strobe bits and wdata=wdata_i>>8(4-k).
REQ-015 For loads, bus_wstrb_o SHALL be 4'b0000 and bus_we_o SHALL be 0.
REQ-016 Load: SHALL capture bus_rdata_i on the ACC1 ack into lo_q and on the ACC2 ack into hi_q. The 64-bit value {hi_q,lo_q}>>8k SHALL give the raw word.
REQ-017 Load result SHALL be sign-extended for LB/LH and zero-extended for LBU/LHU/LW; read_data_o and merged_word_o SHALL be registered and valid in DONE.
REQ-018 Upstream SHALL hold mem_op_i/addr_i/wdata_i/funct3_i stable while stall_o=1; the block SHALL latch them on IDLE->ACC1 and use only the latched copies afterwards.
REQ-019 bus_ack_i outside ACC1/ACC2 SHALL be ignored.
REQ-020 mem_op_i=0 in IDLE SHALL give no bus activity and stall_o=0.
REQ-021 Back-to-back memory ops SHALL pass through DONE->IDLE; each op costs at least one non-stalled cycle.

Reset
REQ-022 While rst=1, SHALL set FSM=IDLE and bus_req_o=0 immediately (asynchronous), including during an outstanding access.
REQ-023 While rst=1, SHALL set bus_we_o=0, bus_wstrb_o=0, bus_addr_o=0, bus_wdata_o=0, read_data_o=0, merged_word_o=0, and lo_q/hi_q=0.
REQ-024 After rst deasserts, the first clock edge SHALL evaluate from IDLE; an ack for an access aborted by reset SHALL be ignored.

Structure
REQ-025 SHALL place the FSM state enum and the LB/LH/LW/LBU/LHU/SB/SH/SW funct3 constants in shared opcodes_pkg.
REQ-026 SHALL instantiate one combinational sub-module load_extend (raw word, offset, funct3 -> extended 32-bit) for both result paths.

Verification
REQ-027 LW 0x100, rdata=0xDEADBEEF, ack in ACC1 -> one bus access, stall_o high 2 cycles, read_data_o=0xDEADBEEF.
REQ-028 LW 0x102, word0=0x11223344, word1=0x55667788 -> accesses to 0x100 then 0x104, merged_word_o=0x77881122, stall_o high 3 cycles.
REQ-029 SW 0x203, wdata=0xAABBCCDD -> 0x200 with wstrb 1000 and data 0xDD000000, then 0x204 with wstrb 0111 and data 0x00AABBCC.
REQ-030 LB 0x301 with rdata 0x0000800F -> 0xFFFFFF80; LHU 0x303 with words 0xAB000000/0x000000CD -> 0x0000CDAB.
REQ-031 LH 0xFFFFFFFF -> second access at 0x00000000; ack delayed 5 cycles -> bus_req_o and stall_o stay high throughout.
REQ-032 rst asserted in ACC2 -> bus_req_o=0 in the same cycle, stall_o=0, a late ack is ignored, and the next LW completes normally.
